// File: rtl/uart_frame_pkg.sv
// Shared constants and state encoding for the UART command frame decoder.
// Frame: sync, opcode, address, optional write data, XOR checksum.
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] OP_READ   = 8'h01;
  localparam logic [7:0] OP_WRITE  = 8'h02;

  typedef enum logic [2:0] {
    S_SYNC,
    S_OP,
    S_ADDR,
    S_DATA,
    S_CHK,
    S_OUT
  } frame_state_t;

endpackage

// File: rtl/uart_frame_decoder.sv
// Assembles checked read/write commands from a received byte stream.
// Bad opcodes, checksum mismatches and stalled frames are dropped and counted.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter int ADDR_BYTES     = 2,
  parameter int DATA_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_data_valid,
  output logic                    rx_data_ready,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic                    cmd_write,
  output logic [8*ADDR_BYTES-1:0] cmd_addr,
  output logic [8*DATA_BYTES-1:0] cmd_wdata,
  output logic                    err_chk,
  output logic                    err_op,
  output logic                    err_timeout,
  output logic [7:0]              err_cnt
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  frame_state_t state, state_nxt;

  logic          accept;
  logic          in_frame;
  logic          last_addr;
  logic          last_data;
  logic          op_bad;
  logic          chk_bad;
  logic          to_hit;
  logic [7:0]    xor_q;
  logic [2:0]    idx_q;
  logic [TW-1:0] to_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          write_q;

  assign accept    = rx_data_valid && rx_data_ready;
  assign last_addr = idx_q == 3'(ADDR_BYTES - 1);
  assign last_data = idx_q == 3'(DATA_BYTES - 1);
  assign in_frame  = state inside {S_OP, S_ADDR, S_DATA, S_CHK};
  // A byte arriving in the expiry cycle wins over the timeout
  assign to_hit    = in_frame && !accept &&
                     to_q == TW'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (rst) state <= S_SYNC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    op_bad    = 1'b0;
    chk_bad   = 1'b0;
    if (to_hit) begin
      state_nxt = S_SYNC;
    end else begin
      unique case (state)
        S_SYNC:
          if (accept && rx_data == SYNC_BYTE)
            state_nxt = S_OP;
        S_OP:
          if (accept) begin
            if (rx_data == OP_READ || rx_data == OP_WRITE) begin
              state_nxt = S_ADDR;
            end else begin
              op_bad    = 1'b1;
              state_nxt = S_SYNC;
            end
          end
        S_ADDR:
          if (accept && last_addr)
            state_nxt = write_q ? S_DATA : S_CHK;
        S_DATA:
          if (accept && last_data)
            state_nxt = S_CHK;
        S_CHK:
          if (accept) begin
            if (rx_data == xor_q) begin
              state_nxt = S_OUT;
            end else begin
              chk_bad   = 1'b1;
              state_nxt = S_SYNC;
            end
          end
        S_OUT:
          if (cmd_ready)
            state_nxt = S_SYNC;
        default:
          state_nxt = S_SYNC;
      endcase
    end
  end

  always_comb begin
    cmd_valid     = state == S_OUT;
    rx_data_ready = state != S_OUT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_chk     <= 1'b0;
      err_op      <= 1'b0;
      err_timeout <= 1'b0;
      err_cnt     <= 8'd0;
      to_q        <= '0;
      xor_q       <= 8'd0;
      idx_q       <= 3'd0;
      addr_q      <= '0;
      data_q      <= '0;
      write_q     <= 1'b0;
    end else begin
      err_chk     <= chk_bad;
      err_op      <= op_bad;
      err_timeout <= to_hit;
      if ((chk_bad || op_bad || to_hit) && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
      if (accept || !in_frame || to_hit)
        to_q <= '0;
      else
        to_q <= to_q + TW'(1);
      if (accept) begin
        unique case (state)
          S_SYNC:
            if (rx_data == SYNC_BYTE) begin
              xor_q  <= 8'd0;
              idx_q  <= 3'd0;
              addr_q <= '0;
              data_q <= '0;
            end
          S_OP: begin
            xor_q   <= rx_data;
            idx_q   <= 3'd0;
            write_q <= rx_data == OP_WRITE;
          end
          S_ADDR: begin
            addr_q <= (addr_q << 8) | AW'(rx_data);
            xor_q  <= xor_q ^ rx_data;
            idx_q  <= last_addr ? 3'd0 : idx_q + 3'd1;
          end
          S_DATA: begin
            data_q <= (data_q << 8) | DW'(rx_data);
            xor_q  <= xor_q ^ rx_data;
            idx_q  <= idx_q + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign cmd_write = write_q;
  assign cmd_addr  = addr_q;
  assign cmd_wdata = data_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder with 2 address and 4 data bytes.
// Expected values are hand-computed from the frame format.
module tb_uart_frame_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        rx_data_ready;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        err_chk;
  logic        err_op;
  logic        err_timeout;
  logic [7:0]  err_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_chk  = 0;
  int n_op   = 0;
  int n_to   = 0;
  int n_cmd  = 0;
  logic cv_d = 1'b0;

  uart_frame_decoder #(
    .ADDR_BYTES(2),
    .DATA_BYTES(4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_data_valid(rx_data_valid),
    .rx_data_ready(rx_data_ready),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .err_chk(err_chk),
    .err_op(err_op),
    .err_timeout(err_timeout),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (err_chk) n_chk++;
    if (err_op) n_op++;
    if (err_timeout) n_to++;
    if (cmd_valid && !cv_d) n_cmd++;
    cv_d <= cmd_valid;
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data       = b;
    rx_data_valid = 1'b1;
    for (int i = 0; i < 50 && !rx_data_ready; i++) tick();
    tick();
    rx_data_valid = 1'b0;
  endtask

  task automatic send_write(input logic [7:0] chk);
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hDE); send_byte(8'hAD);
    send_byte(8'hBE); send_byte(8'hEF);
    send_byte(chk);
  endtask

  task automatic send_read();
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h10);
    send_byte(8'h11);
  endtask

  task automatic expect_read(input string tag);
    check({tag, "_valid"}, cmd_valid, 1);
    check({tag, "_write"}, cmd_write, 0);
    check({tag, "_addr"}, cmd_addr, 64'h0010);
    check({tag, "_wdata"}, cmd_wdata, 0);
    tick();
    check({tag, "_drop"}, cmd_valid, 0);
  endtask

  int base_cmd;
  int unstable;
  int to_wait;

  initial begin
    rst = 1'b1;
    rx_data = 8'h00;
    rx_data_valid = 1'b0;
    cmd_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_ready", rx_data_ready, 1);
    check("rst_valid", cmd_valid, 0);
    check("rst_errcnt", err_cnt, 0);
    check("rst_errs", {err_chk, err_op, err_timeout}, 0);
    check("rst_write", cmd_write, 0);

    send_write(8'h06);
    check("wr_valid", cmd_valid, 1);
    check("wr_write", cmd_write, 1);
    check("wr_addr", cmd_addr, 64'h1234);
    check("wr_wdata", cmd_wdata, 64'hDEADBEEF);
    check("wr_ready_low", rx_data_ready, 0);
    tick();
    check("wr_drop", cmd_valid, 0);
    check("wr_ready_back", rx_data_ready, 1);
    check("wr_no_err", n_chk + n_op + n_to, 0);

    send_read();
    expect_read("rd");

    base_cmd = n_cmd;
    send_write(8'h07);
    repeat (2) tick();
    check("badchk_pulses", n_chk, 1);
    check("badchk_nocmd", n_cmd - base_cmd, 0);
    check("badchk_errcnt", err_cnt, 1);
    send_read();
    expect_read("rd2");

    send_byte(8'h00); send_byte(8'hFF);
    send_byte(8'hA5); send_byte(8'h03);
    check("badop_pulse", err_op, 1);
    send_read();
    expect_read("rd3");
    check("badop_pulses", n_op, 1);
    check("badop_errcnt", err_cnt, 2);

    cmd_ready = 1'b0;
    send_write(8'h06);
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      if (rx_data_ready !== 1'b0 || cmd_valid !== 1'b1 ||
          cmd_write !== 1'b1 || cmd_addr !== 16'h1234 ||
          cmd_wdata !== 32'hDEADBEEF)
        unstable++;
      tick();
    end
    check("hold_stable", unstable, 0);
    cmd_ready = 1'b1;
    tick();
    check("hold_drop", cmd_valid, 0);
    check("hold_ready", rx_data_ready, 1);
    send_read();
    expect_read("rd4");

    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    to_wait = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (err_timeout) begin
        to_wait = i;
        break;
      end
    end
    check("to_delay", to_wait, 64);
    tick();
    check("to_one_pulse", err_timeout, 0);
    check("to_errcnt", err_cnt, 3);
    send_read();
    expect_read("rd5");
    check("to_pulses", n_to, 1);

    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_errcnt", err_cnt, 0);
    check("mrst_ready", rx_data_ready, 1);
    check("mrst_valid", cmd_valid, 0);
    send_read();
    expect_read("rd6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
